// File: rtl/mm_sequencer.sv
// Sequences one shared signed MAC over external A/B RAMs to compute C = A x B, one C element per write.
// Optional MM_SEQ_RELU_EN: clamp negative saturated results to zero before they are written.
module mm_sequencer #(
    parameter int N     = 3,
    parameter int DIN   = 3,
    parameter int DOUT  = 3,
    parameter int WIDTH = 8,
    localparam int AW_A = (N * DIN > 1) ? $clog2(N * DIN) : 1,
    localparam int AW_B = (DIN * DOUT > 1) ? $clog2(DIN * DOUT) : 1,
    localparam int AW_C = (N * DOUT > 1) ? $clog2(N * DOUT) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      a_rd_en_o,
    output logic [AW_A-1:0]           a_addr_o,
    input  logic signed [WIDTH-1:0]   a_rdata_i,
    output logic                      b_rd_en_o,
    output logic [AW_B-1:0]           b_addr_o,
    input  logic signed [WIDTH-1:0]   b_rdata_i,
    output logic                      c_we_o,
    output logic [AW_C-1:0]           c_addr_o,
    output logic signed [2*WIDTH-1:0] c_wdata_o
);

    // state | meaning
    // IDLE  | waiting for start_i
    // RUN   | one A/B read issued per cycle, k innermost, then j, then i
    // DRAIN | reads finished, MAC pipeline emptying until the last C write
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int JW   = (DOUT > 1) ? $clog2(DOUT) : 1;
    localparam int KW   = (DIN > 1) ? $clog2(DIN) : 1;
    localparam int ACCW = 2 * WIDTH + $clog2(DIN) + 1;

    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-2*WIDTH+1){1'b0}}, {(2*WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    state_t                    state_q, state_d;
    logic [IW-1:0]             i_q, i_d;
    logic [JW-1:0]             j_q, j_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      run, last_i, last_j, last_k;
    logic [AW_C-1:0]           caddr;

    logic                      v1_q, first1_q, last1_q;
    logic [AW_C-1:0]           caddr1_q;
    logic signed [ACCW-1:0]    acc_q, acc_sum;
    logic signed [2*WIDTH-1:0] prod, res_sat, res;
    logic                      c_we_q;
    logic [AW_C-1:0]           c_addr_q;
    logic signed [2*WIDTH-1:0] c_wdata_q;

    assign run    = (state_q == S_RUN);
    assign last_i = (i_q == IW'(N - 1));
    assign last_j = (j_q == JW'(DOUT - 1));
    assign last_k = (k_q == KW'(DIN - 1));
    assign caddr  = AW_C'(i_q * DOUT + j_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (last_k) begin
                    k_d = '0;
                    if (last_j) begin
                        j_d = '0;
                        if (last_i) begin
                            i_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            // The last write is visible once the read pipeline has emptied.
            S_DRAIN: begin
                if (c_we_q && !v1_q) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o    = run || (state_q == S_DRAIN);
    assign done_o    = (state_q == S_DONE);
    assign a_rd_en_o = run;
    assign b_rd_en_o = run;
    assign a_addr_o  = run ? AW_A'(i_q * DIN + k_q) : '0;
    assign b_addr_o  = run ? AW_B'(k_q * DOUT + j_q) : '0;

    assign prod = $signed({{WIDTH{a_rdata_i[WIDTH-1]}}, a_rdata_i})
                * $signed({{WIDTH{b_rdata_i[WIDTH-1]}}, b_rdata_i});

    always_comb begin
        acc_sum = first1_q ? ACCW'(prod) : acc_q + ACCW'(prod);
        if (acc_sum > SAT_MAX) begin
            res_sat = {1'b0, {(2*WIDTH-1){1'b1}}};
        end else if (acc_sum < SAT_MIN) begin
            res_sat = {1'b1, {(2*WIDTH-1){1'b0}}};
        end else begin
            res_sat = acc_sum[2*WIDTH-1:0];
        end
        res = res_sat;
`ifdef MM_SEQ_RELU_EN
        if (res_sat[2*WIDTH-1]) res = '0;
`endif
    end

    // Tags travel with each read so the data stage knows when to load, add and write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1_q      <= 1'b0;
            first1_q  <= 1'b0;
            last1_q   <= 1'b0;
            caddr1_q  <= '0;
            acc_q     <= '0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
        end else begin
            v1_q     <= run;
            first1_q <= run && (k_q == '0);
            last1_q  <= run && last_k;
            caddr1_q <= run ? caddr : '0;
            if (v1_q) acc_q <= acc_sum;
            c_we_q <= v1_q && last1_q;
            if (v1_q && last1_q) begin
                c_addr_q  <= caddr1_q;
                c_wdata_q <= res;
            end
        end
    end

    assign c_we_o    = c_we_q;
    assign c_addr_o  = c_addr_q;
    assign c_wdata_o = c_wdata_q;

endmodule

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
Controller that sequences a single shared signed MAC to compute C = A x B for one feed-forward layer.
- A (N x DIN) and B (DIN x DOUT) are read from external synchronous RAMs.
- C (N x DOUT) is written back one element at a time.
- Replaces the fully parallel multiply where area matters. Started by the FFN top-level controller; reports completion with a done pulse.

Parameters:
- N, 3: rows of A and C (sentence length).
- DIN, 3: inner dimension (columns of A, rows of B).
- DOUT, 3: columns of B and C.
- WIDTH, 8: signed bit width of A/B elements; C elements are 2*WIDTH.
- Derived localparams: AW_A = clog2(N*DIN), AW_B = clog2(DIN*DOUT), AW_C = clog2(N*DOUT), ACCW = 2*WIDTH + clog2(DIN) + 1.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: request a run; sampled only in IDLE.
- busy, out, 1: high while a run is in progress.
- done, out, 1: one-cycle pulse after the final C write.
- a_rd_en, out, 1: A RAM read enable.
- a_addr, out, AW_A: A address = i*DIN + k (row-major).
- a_rdata, in, WIDTH signed: A data, valid 1 cycle after a_rd_en.
- b_rd_en, out, 1: B RAM read enable.
- b_addr, out, AW_B: B address = k*DOUT + j.
- b_rdata, in, WIDTH signed: B data, valid 1 cycle after b_rd_en.
- c_we, out, 1: C write strobe.
- c_addr, out, AW_C: C address = i*DOUT + j.
- c_wdata, out, 2*WIDTH signed: C element value.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; all outputs 0; counters i, j, k = 0; accumulator = 0.
- States:
  - IDLE -> RUN when start = 1.
  - RUN -> DRAIN after the read with i=N-1, j=DOUT-1, k=DIN-1 is issued.
  - DRAIN -> DONE once the final c_we has been issued.
  - DONE -> IDLE unconditionally after 1 cycle.
- busy = 1 in RUN and DRAIN; 0 in IDLE and DONE.
- done = 1 only in DONE.
- Issue order: k innermost, then j, then i; one read per cycle in RUN.
  - a_rd_en = b_rd_en = 1 throughout RUN, with no bubbles.
- MAC pipeline:
  - Issue cycle t: addresses driven.
  - Cycle t+1: product = a_rdata * b_rdata, full 2*WIDTH signed.
  - Accumulator loads the product when k=0, otherwise adds it. A k/last tag is pipelined alongside the read.
  - When the tagged k = DIN-1: at end of t+1, register c_wdata = sat(acc + product) and c_addr for (i, j).
  - c_we = 1 for exactly one cycle (t+2).
- Saturation: the ACCW-bit sum is clamped to [-2^(2W-1), 2^(2W-1)-1].
- Timing: with start sampled at edge 0, T = N*DOUT*DIN.
  - Reads are issued in cycles 1..T.
  - Final c_we occurs in cycle T+2.
  - done occurs in cycle T+3.
  - Exactly N*DOUT writes per run, in ascending c_addr order.
- Boundary conditions:
  - start while busy or done is ignored, with no effect on counters.
  - start held high continuously re-launches a run on the cycle after DONE, i.e. in IDLE.
  - DIN = 1: every read is a last-k read; one write per issue cycle, back-to-back.
  - Reset asserted mid-run aborts immediately: no further reads or writes, and no done pulse.
  - Counter wrap: k wraps to 0 and j increments; j wraps to 0 and i increments; there is no wrap past i = N-1.
  - Read-enable and address outputs are 0 outside RUN.

Optional Feature:
- MM_SEQ_RELU_EN defined: c_wdata = 0 whenever the saturated result is negative (fused FFN ReLU). Timing is unchanged.
- Not defined: the signed saturated result is written unmodified.

Test Plan:
1. N=DIN=DOUT=2, A=[[1,2],[3,4]], B=identity, start pulse at cycle 0 -> writes (addr,data) (0,1),(1,2),(2,3),(3,4); final c_we in cycle 10; done in cycle 11; busy high in cycles 1..10.
2. WIDTH=8, DIN=2, all A and B = -128 -> every c_wdata = 32767 (saturated; true sum 32768).
3. Start pulsed again at cycle 4 of a 2x2x2 run -> ignored; exactly 4 writes and a single done pulse.
4. Reset driven low at cycle 5 of a run -> all outputs 0 the same cycle; no done pulse; a following start produces a correct full run.
5. N=3, DIN=1, DOUT=3, A=[1,-2,3], B=[2,2,2] -> 9 back-to-back writes: 2,2,2,-4,-4,-4,6,6,6 (with MM_SEQ_RELU_EN: -4 becomes 0).
6. start held high for 40 cycles with N=DIN=DOUT=2 -> consecutive runs with exactly one IDLE cycle between a done pulse and the next busy.
